log2_unit: RTL



---
 rtl/log2_pkg.sv | 24 ++
 rtl/log2_unit_lod64.sv | 17 +
 rtl/log2_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/log2_pkg.sv
// Shared constants for log2_unit: Q formats, segment count, and the chord LUT for log2(1+f).
// Each segment's line passes through the curve at both ends. B[0] is 0, so exact powers of two give exact results.
package log2_pkg;

  localparam int W_IN         = 64;
  localparam int Q_IN         = 16;
  localparam int W_OUT        = 32;
  localparam int Q_OUT        = 22;
  localparam int NUM_SEGMENTS = 8;

  typedef logic [2:0] seg_t;

  // Slopes and intercepts in Q10.22 over the full fraction f (not segment-local).
  localparam logic [W_OUT-1:0] LUT_K [NUM_SEGMENTS] = '{
    32'd5701737, 32'd5100377, 32'd4613853, 32'd4212117,
    32'd3874772, 32'd3587479, 32'd3339863, 32'd3124233
  };

  localparam logic [W_OUT-1:0] LUT_B [NUM_SEGMENTS] = '{
    32'd0,       32'd75170,   32'd196801,  32'd347452,
    32'd516124,  32'd695683,  32'd881395,  32'd1070071
  };

endpackage

// File: rtl/log2_unit_lod64.sv
// Combinational leading-one detector for a 63-bit vector.
// Returns the index of the highest set bit and a flag for an all-zero input.
module lod64 (
  input  logic [62:0] in_vec,
  output logic [5:0]  pos,
  output logic        zero
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < 63; i++) begin
      if (in_vec[i]) pos = 6'(i);
    end
    zero = ~|in_vec;
  end

endmodule

// File: rtl/log2_unit.sv
// Three-stage log2 pipeline: Q48.16 in, Q10.22 out, valid/ready with a single global advance.
// Build option LOG2_ROUND_EN: when defined, the normalized fraction is rounded to nearest instead of truncated.
import log2_pkg::*;

module log2_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_OUT-1:0]  out_log2,
  output logic              out_err
);

  logic              advance;

  logic              s1_valid_q, s1_valid_d;
  logic [W_IN-1:0]   s1_x_q,     s1_x_d;
  logic [5:0]        s1_p_q,     s1_p_d;
  logic              s1_err_q,   s1_err_d;

  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        s2_ip_q,    s2_ip_d;
  logic [Q_OUT-1:0]  s2_f_q,     s2_f_d;
  logic              s2_err_q,   s2_err_d;

  logic              s3_valid_q, s3_valid_d;
  logic [W_OUT-1:0]  s3_log2_q,  s3_log2_d;
  logic              s3_err_q,   s3_err_d;

  logic [5:0]        lod_pos;
  logic              lod_zero;
  logic [5:0]        shamt;
  logic [W_IN-1:0]   m;
  logic [Q_OUT-1:0]  f_trunc;
  logic              unused_m;
  seg_t              seg;
  logic signed [53:0] prod;
  logic [W_OUT-1:0]  ip_ext;

  assign advance   = !s3_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign out_log2  = s3_log2_q;
  assign out_err   = s3_err_q;

  lod64 u_lod (
    .in_vec (in_x[62:0]),
    .pos    (lod_pos),
    .zero   (lod_zero)
  );

  // Leading one lands on bit 62, so the 22 bits below it are the fraction.
  assign shamt    = 6'd62 - s1_p_q;
  assign m        = s1_x_q << shamt;
  assign f_trunc  = m[61:40];
  assign unused_m = ^{m[63:62], m[39:0]};

  assign seg    = s2_f_q[Q_OUT-1 -: 3];
  assign prod   = $signed({22'b0, LUT_K[seg]}) * $signed({32'b0, s2_f_q});
  assign ip_ext = {{24{s2_ip_q[7]}}, s2_ip_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_p_d     = s1_p_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_ip_d    = s2_ip_q;
    s2_f_d     = s2_f_q;
    s2_err_d   = s2_err_q;
    s3_valid_d = s3_valid_q;
    s3_log2_d  = s3_log2_q;
    s3_err_d   = s3_err_q;

    if (advance) begin
      s1_valid_d = in_valid;
      s1_x_d     = in_x;
      s1_p_d     = lod_pos;
      s1_err_d   = in_x[W_IN-1] | lod_zero;

      s2_valid_d = s1_valid_q;
      s2_ip_d    = 8'(s1_p_q) - 8'(Q_IN);
      s2_err_d   = s1_err_q;
`ifdef LOG2_ROUND_EN
      if (m[39]) s2_f_d = (&f_trunc) ? '1 : f_trunc + 22'd1;
      else       s2_f_d = f_trunc;
`else
      s2_f_d     = f_trunc;
`endif

      s3_valid_d = s2_valid_q;
      s3_err_d   = s2_err_q;
      if (s2_err_q) s3_log2_d = 32'h8000_0000;
      else          s3_log2_d = (ip_ext << Q_OUT) + 32'(prod >>> Q_OUT) + LUT_B[seg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_p_q     <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_ip_q    <= '0;
      s2_f_q     <= '0;
      s2_err_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_log2_q  <= '0;
      s3_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_p_q     <= s1_p_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_ip_q    <= s2_ip_d;
      s2_f_q     <= s2_f_d;
      s2_err_q   <= s2_err_d;
      s3_valid_q <= s3_valid_d;
      s3_log2_q  <= s3_log2_d;
      s3_err_q   <= s3_err_d;
    end
  end

endmodule
